// File: rtl/pe_adder_tree_acc_if.sv
// pe_adder_tree_acc_if
// Bundles the beat input bus and the group result bus of pe_adder_tree_acc.
//   in_valid  : beat valid (no backpressure)
//   in_p      : N_IN packed signed products, product i at [i*P_W +: P_W]
//   in_shift  : left shift applied to this beat's tree sum
//   in_first  : beat starts a new accumulation group
//   in_last   : beat ends the group and produces a result
//   out_valid : one-cycle pulse, out_sum/out_sat hold a completed group
//   out_sum   : signed saturated accumulation result
//   out_sat   : saturation happened somewhere in the reported group
// master drives beats and receives results; slave is the accumulator.
interface pe_adder_tree_acc_if #(
    parameter int N_IN  = 16,
    parameter int P_W   = 6,
    parameter int SH_W  = 3,
    parameter int ACC_W = 24
);
    logic                   in_valid;
    logic [N_IN*P_W-1:0]    in_p;
    logic [SH_W-1:0]        in_shift;
    logic                   in_first;
    logic                   in_last;
    logic                   out_valid;
    logic [ACC_W-1:0]       out_sum;
    logic                   out_sat;

    modport master (
        output in_valid, in_p, in_shift, in_first, in_last,
        input  out_valid, out_sum, out_sat
    );

    modport slave (
        input  in_valid, in_p, in_shift, in_first, in_last,
        output out_valid, out_sum, out_sat
    );
endinterface

// File: rtl/pe_adder_tree_acc.sv
// pe_adder_tree_acc
// Registered binary adder tree over N_IN signed partial products, followed by
// a shift-and-accumulate stage with saturation over first/last framed groups.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_if : pe_adder_tree_acc_if.slave (beat inputs, group result outputs)
// Latency: a beat captured on edge E updates the accumulator on edge E+L+1;
// the group result pulse is visible in the following cycle.
module pe_adder_tree_acc #(
    parameter int N_IN  = 16,
    parameter int P_W   = 6,
    parameter int SH_W  = 3,
    parameter int ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_adder_tree_acc_if.slave   bus_if
);
    localparam int L   = $clog2(N_IN);
    localparam int S_W = P_W + L;

    // All tree levels live in one flat register. Level 0 is the input
    // capture register, level k holds N_IN>>k sums of width P_W+k.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) o += (N_IN >> j) * (P_W + j);
        return o;
    endfunction

    localparam int TREE_BITS = lvl_off(L + 1);
    localparam int TREE_OUT  = lvl_off(L);

    logic [TREE_BITS-1:0] tree_q, tree_d;

    assign tree_d[N_IN*P_W-1:0] = bus_if.in_p;

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int W   = P_W + k;
        localparam int SRC = lvl_off(k - 1);
        localparam int DST = lvl_off(k);
        for (genvar i = 0; i < (N_IN >> k); i++) begin : g_add
            logic [W-2:0] a, b;
            assign a = tree_q[SRC + (2*i)*(W-1)   +: W-1];
            assign b = tree_q[SRC + (2*i+1)*(W-1) +: W-1];
            // One bit of growth per level keeps every add exact.
            assign tree_d[DST + i*W +: W] = {a[W-2], a} + {b[W-2], b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tree_q <= '0;
        else     tree_q <= tree_d;
    end

    // Sideband: stage 0 aligns with the input capture, stage L with the
    // tree output register.
    logic [L:0]      vld_q, fst_q, lst_q;
    logic [SH_W-1:0] sh_q [L+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            fst_q <= '0;
            lst_q <= '0;
            for (int j = 0; j <= L; j++) sh_q[j] <= '0;
        end else begin
            vld_q <= {vld_q[L-1:0], bus_if.in_valid};
            fst_q <= {fst_q[L-1:0], bus_if.in_first};
            lst_q <= {lst_q[L-1:0], bus_if.in_last};
            sh_q[0] <= bus_if.in_shift;
            for (int j = 1; j <= L; j++) sh_q[j] <= sh_q[j-1];
        end
    end

    logic             v_s, first_s, last_s;
    logic [S_W-1:0]   tree_sum;
    logic [ACC_W-1:0] term;
    logic [ACC_W:0]   nxt;
    logic             clip;
    logic [ACC_W-1:0] acc_q, acc_d, acc_clip;
    logic             sat_q, sat_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_sat_q, out_sat_d;

    assign v_s      = vld_q[L];
    assign first_s  = fst_q[L];
    assign last_s   = lst_q[L];
    assign tree_sum = tree_q[TREE_OUT +: S_W];

    always_comb begin
        term = {{(ACC_W-S_W){tree_sum[S_W-1]}}, tree_sum} << sh_q[L];
        if (first_s) nxt = {term[ACC_W-1], term};
        else         nxt = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
        // Overflow of the ACC_W-bit range shows as disagreeing top bits;
        // the extra sign bit picks which rail to clip to.
        clip     = nxt[ACC_W] ^ nxt[ACC_W-1];
        acc_clip = clip ? {nxt[ACC_W], {(ACC_W-1){~nxt[ACC_W]}}} : nxt[ACC_W-1:0];

        acc_d = acc_q;
        sat_d = sat_q;
        if (v_s) begin
            acc_d = acc_clip;
            sat_d = (first_s ? 1'b0 : sat_q) | clip;
        end

        out_valid_d = v_s & last_s;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        if (v_s && last_s) begin
            out_sum_d = acc_d;
            out_sat_d = sat_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_sum   = out_sum_q;
    assign bus_if.out_sat   = out_sat_q;
endmodule
